// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//   8N1 UART receiver. The asynchronous line is brought into the clock
//   domain through a two-flop synchronizer. A down-counter places one sample
//   in the middle of each bit. The received byte goes into a one-entry
//   valid/ready holding register.
//
// Parameters
//   BAUD_DIV     clock cycles per serial bit (4..65535)
//
// Ports
//   wb_clk_i     in   1  sole clock
//   wb_rst_i     in   1  synchronous, active-high reset
//   rx_i         in   1  asynchronous serial line, idle high
//   rx_data_o    out  8  received byte, valid while rx_valid_o=1
//   rx_valid_o   out  1  holding register full
//   rx_ready_i   in   1  consumer accepts byte when rx_valid_o & rx_ready_i
//   frame_err_o  out  1  one-cycle pulse: stop bit sampled low
//   overrun_o    out  1  one-cycle pulse: byte completed while register full
//   busy_o       out  1  receiver not idle
// ---------------------------------------------------------------------------
module uart_rx_core #(
   parameter int unsigned BAUD_DIV = 4167
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o
);

   // The first reload is half a bit, so every later sample lands mid-bit.
   localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
   localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BRK
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_sync1, r_sync2;
   logic [15:0] r_cnt, w_cnt_nxt;
   logic [2:0]  r_bitidx, w_bitidx_nxt;
   logic [7:0]  r_shreg, w_shreg_nxt;
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_frame_err;
   logic        r_overrun;

   logic        w_rx_s;
   logic        w_cnt_zero;
   logic        w_deliver;
   logic        w_frame_err;
   logic        w_accept;

   assign w_rx_s     = r_sync2;
   assign w_cnt_zero = (r_cnt == 16'd0);
   assign w_accept   = r_valid & rx_ready_i;

   // Next-state logic. Each state reloads or decrements the counter and acts
   // only on the sample taken when the counter reaches zero.
   always_comb begin
      // NOTE: each output gets a default before the case. A path that leaves
      // a signal unassigned would otherwise infer a latch.
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_bitidx_nxt = r_bitidx;
      w_shreg_nxt  = r_shreg;
      w_deliver    = 1'b0;
      w_frame_err  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (!w_rx_s) begin
               w_state_nxt = S_START;
               w_cnt_nxt   = HALF_M1;
            end
         end
         S_START: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 16'd1;
            end else if (!w_rx_s) begin
               w_state_nxt  = S_DATA;
               w_cnt_nxt    = FULL_M1;
               w_bitidx_nxt = 3'd0;
            end else begin
               // The line was high again at mid-start-bit, so the low was a
               // glitch. Drop it without raising any flag.
               w_state_nxt = S_IDLE;
            end
         end
         S_DATA: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 16'd1;
            end else begin
               w_shreg_nxt  = {w_rx_s, r_shreg[7:1]};
               w_cnt_nxt    = FULL_M1;
               w_bitidx_nxt = r_bitidx + 3'd1;
               if (r_bitidx == 3'd7) begin
                  w_state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (!w_cnt_zero) begin
               w_cnt_nxt = r_cnt - 16'd1;
            end else if (w_rx_s) begin
               w_deliver   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_frame_err = 1'b1;
               w_state_nxt = S_BRK;
            end
         end
         S_BRK: begin
            // Wait for the line to go high, so a held-low break is not read
            // as a stream of start bits.
            if (w_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      // NOTE: every register here uses non-blocking assignment. All flops
      // therefore update from the values present before the edge.
      if (wb_rst_i) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_state     <= S_IDLE;
         r_cnt       <= 16'd0;
         r_bitidx    <= 3'd0;
         r_shreg     <= 8'd0;
         r_data      <= 8'd0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         // Two-flop synchronizer. Only r_sync2 feeds any logic.
         r_sync1     <= rx_i;
         r_sync2     <= r_sync1;
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bitidx    <= w_bitidx_nxt;
         r_shreg     <= w_shreg_nxt;
         r_frame_err <= w_frame_err;
         r_overrun   <= 1'b0;

         if (w_deliver) begin
            // A consumer reading in the same cycle frees the slot. The new
            // byte then loads directly and valid stays high.
            if (!r_valid || rx_ready_i) begin
               r_data  <= r_shreg;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data_o   = r_data;
   assign rx_valid_o  = r_valid;
   assign frame_err_o = r_frame_err;
   assign overrun_o   = r_overrun;
   assign busy_o      = (r_state != S_IDLE);

endmodule
